// File: rtl/packet_rr_arbiter_8chs.sv
// Packet-atomic round-robin arbiter: merges NUM_PORTS Avalon-ST requesters into one
// channel-tagged stream, holding the grant from SOP through EOP behind a registered output stage.
module packet_rr_arbiter_8chs #(
    parameter int NUM_PORTS     = 8,
    parameter int CHANNEL_WIDTH = 3,
    parameter int DATA_WIDTH    = 128,
    parameter int EMPTY_WIDTH   = 4,
    parameter int ERROR_WIDTH   = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS-1:0]               i_port_enable,
    input  logic [NUM_PORTS-1:0]               i_avst_valid,
    output logic [NUM_PORTS-1:0]               o_avst_ready,
    input  logic [NUM_PORTS-1:0]               i_avst_startofpacket,
    input  logic [NUM_PORTS-1:0]               i_avst_endofpacket,
    input  logic [NUM_PORTS*ERROR_WIDTH-1:0]   i_avst_error,
    input  logic [NUM_PORTS*EMPTY_WIDTH-1:0]   i_avst_empty,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    i_avst_data,
    output logic                               o_avst_valid,
    input  logic                               i_avst_ready,
    output logic                               o_avst_startofpacket,
    output logic                               o_avst_endofpacket,
    output logic [CHANNEL_WIDTH-1:0]           o_avst_channel,
    output logic [ERROR_WIDTH-1:0]             o_avst_error,
    output logic [EMPTY_WIDTH-1:0]             o_avst_empty,
    output logic [DATA_WIDTH-1:0]              o_avst_data,
    output logic [NUM_PORTS-1:0]               o_grant,
    output logic                               o_busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    if (CHANNEL_WIDTH < $clog2(NUM_PORTS)) begin : g_chan_width_check
        $error("CHANNEL_WIDTH too narrow to encode NUM_PORTS");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state_q, state_d;
    logic [NUM_PORTS-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic                     busy_q, busy_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_sop_q, out_sop_d;
    logic                     out_eop_q, out_eop_d;
    logic [CHANNEL_WIDTH-1:0] out_channel_q, out_channel_d;
    logic [ERROR_WIDTH-1:0]   out_error_q, out_error_d;
    logic [EMPTY_WIDTH-1:0]   out_empty_q, out_empty_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;

    logic [NUM_PORTS-1:0]     req;
    logic [NUM_PORTS-1:0]     ready_vec;
    logic                     out_ok;
    logic                     accept;
    logic                     found;
    logic [IDX_W-1:0]         winner;
    logic [IDX_W-1:0]         cand;
    logic                     own_valid;
    logic                     own_sop;
    logic                     own_eop;
    logic [ERROR_WIDTH-1:0]   own_error;
    logic [EMPTY_WIDTH-1:0]   own_empty;
    logic [DATA_WIDTH-1:0]    own_data;

    // The owner index is last_grant_q: it is loaded with the winner whenever a grant is issued.
    always_comb begin
        req       = i_avst_valid & i_avst_startofpacket & i_port_enable;
        out_ok    = ~out_valid_q | i_avst_ready;
        ready_vec = (state_q == BUSY && out_ok) ? grant_q : '0;
        own_valid = i_avst_valid[last_grant_q];
        own_sop   = i_avst_startofpacket[last_grant_q];
        own_eop   = i_avst_endofpacket[last_grant_q];
        own_error = i_avst_error[int'(last_grant_q)*ERROR_WIDTH +: ERROR_WIDTH];
        own_empty = i_avst_empty[int'(last_grant_q)*EMPTY_WIDTH +: EMPTY_WIDTH];
        own_data  = i_avst_data[int'(last_grant_q)*DATA_WIDTH +: DATA_WIDTH];
        accept    = (state_q == BUSY) && out_ok && own_valid;
    end

    // Round-robin search starting one past the previous winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        busy_d        = busy_q;
        out_valid_d   = out_valid_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_channel_d = out_channel_q;
        out_error_d   = out_error_q;
        out_empty_d   = out_empty_q;
        out_data_d    = out_data_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = BUSY;
                    grant_d      = NUM_PORTS'(1) << winner;
                    last_grant_d = winner;
                    busy_d       = 1'b1;
                end
            end
            BUSY: begin
                if (accept && own_eop) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // The output register drains in either state; it only loads on an accepted owner beat.
        if (accept) begin
            out_valid_d   = 1'b1;
            out_sop_d     = own_sop;
            out_eop_d     = own_eop;
            out_channel_d = CHANNEL_WIDTH'(last_grant_q);
            out_error_d   = own_error;
            out_empty_d   = own_empty;
            out_data_d    = own_data;
        end else if (out_ok) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= IDX_W'(NUM_PORTS - 1);
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_channel_q <= '0;
            out_error_q   <= '0;
            out_empty_q   <= '0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_channel_q <= out_channel_d;
            out_error_q   <= out_error_d;
            out_empty_q   <= out_empty_d;
            out_data_q    <= out_data_d;
        end
    end

    assign o_avst_ready         = ready_vec;
    assign o_avst_valid         = out_valid_q;
    assign o_avst_startofpacket = out_sop_q;
    assign o_avst_endofpacket   = out_eop_q;
    assign o_avst_channel       = out_channel_q;
    assign o_avst_error         = out_error_q;
    assign o_avst_empty         = out_empty_q;
    assign o_avst_data          = out_data_q;
    assign o_grant              = grant_q;
    assign o_busy               = busy_q;

endmodule

// File: tb/tb_packet_rr_arbiter_8chs.sv
// Testbench for packet_rr_arbiter_8chs: a cycle table for the basic packet path, then
// hand-written sequences driven by a small per-port packet source model.
module tb_packet_rr_arbiter_8chs;

    localparam int NP = 8;
    localparam int CW = 3;
    localparam int DW = 128;
    localparam int EW = 4;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] port_en, in_valid, in_sop, in_eop, ready_vec, grant;
    logic [NP*RW-1:0] in_err;
    logic [NP*EW-1:0] in_empty;
    logic [NP*DW-1:0] in_data;
    logic          o_valid, rdy, o_sop, o_eop, busy;
    logic [CW-1:0] o_ch;
    logic [RW-1:0] o_err;
    logic [EW-1:0] o_empty;
    logic [DW-1:0] o_data;

    always #5 clk = ~clk;

    packet_rr_arbiter_8chs #(
        .NUM_PORTS(NP), .CHANNEL_WIDTH(CW), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .ERROR_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst), .i_port_enable(port_en),
        .i_avst_valid(in_valid), .o_avst_ready(ready_vec),
        .i_avst_startofpacket(in_sop), .i_avst_endofpacket(in_eop),
        .i_avst_error(in_err), .i_avst_empty(in_empty), .i_avst_data(in_data),
        .o_avst_valid(o_valid), .i_avst_ready(rdy),
        .o_avst_startofpacket(o_sop), .o_avst_endofpacket(o_eop),
        .o_avst_channel(o_ch), .o_avst_error(o_err), .o_avst_empty(o_empty),
        .o_avst_data(o_data), .o_grant(grant), .o_busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source model: each port emits m_pkts packets of m_len beats.
    int m_pkts[NP], m_len[NP], m_beat[NP], m_pktno[NP], eop_cyc[NP];

    typedef struct {
        logic [CW-1:0] ch;
        logic          sop, eop;
        logic [DW-1:0] data;
        int            c;
    } beat_t;
    beat_t mon[$];

    function automatic logic [DW-1:0] beat_data(input int p, input int n, input int b);
        return DW'(((p & 255) << 16) | ((n & 255) << 8) | (b & 255));
    endfunction

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            m_pkts[p] = 0; m_len[p] = 1; m_beat[p] = 0; m_pktno[p] = 0; eop_cyc[p] = -1;
        end
        mon.delete();
    endtask

    task automatic drive_model();
        for (int p = 0; p < NP; p++) begin
            in_valid[p] = (m_pkts[p] > 0);
            in_sop[p]   = (m_beat[p] == 0);
            in_eop[p]   = (m_beat[p] == m_len[p] - 1);
            in_data[p*DW +: DW]  = beat_data(p, m_pktno[p], m_beat[p]);
            in_err[p*RW +: RW]   = RW'(p);
            in_empty[p*EW +: EW] = EW'(m_beat[p]);
        end
    endtask

    task automatic finish_cycle();
        logic [NP-1:0] acc;
        beat_t b;
        acc = in_valid & ready_vec;
        if (o_valid && rdy) begin
            b.ch = o_ch; b.sop = o_sop; b.eop = o_eop; b.data = o_data; b.c = cyc + 1;
            mon.push_back(b);
        end
        @(posedge clk);
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                if (m_beat[p] == m_len[p] - 1) begin
                    eop_cyc[p] = cyc;
                    m_beat[p] = 0; m_pkts[p]--; m_pktno[p]++;
                end else begin
                    m_beat[p]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        drive_model();
        #1;
        finish_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        drive_model();
        port_en = '1;
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic       v, s, e;
        logic [7:0] d;
        logic [3:0] emp;
        logic       r;
        logic [7:0] x_rdy, x_gnt;
        logic       x_busy, x_ov, x_sop, x_eop;
        logic [7:0] x_data;
        logic [3:0] x_emp;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, g0cyc, rdy0_seen;

        // Port 3, one 4-beat packet: grant, 4 output beats, release, then idle.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h10, 4'h0, 1'b1, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h10, 4'h0, 1'b1, 8'h08, 8'h08, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 4'h0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h11, 4'h0, 1'b1, 8'h08, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 4'h0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h12, 4'h0, 1'b1, 8'h08, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 4'h0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h13, 4'h5, 1'b1, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 4'h5};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0};

        rst = 1'b1;
        model_clear();
        drive_model();
        port_en = '1;
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset valid", o_valid, 0);
        chk("reset grant", grant, 0);
        chk("reset busy", busy, 0);
        chk("reset ready", ready_vec, 0);
        chk("reset sop/eop", {o_sop, o_eop}, 0);
        chk("reset fields", {o_ch, o_err, o_empty, o_data}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            in_valid = '0; in_sop = '0; in_eop = '0;
            in_valid[3] = tbl[i].v;
            in_sop[3]   = tbl[i].s;
            in_eop[3]   = tbl[i].e;
            in_data[3*DW +: DW]  = DW'(tbl[i].d);
            in_empty[3*EW +: EW] = tbl[i].emp;
            in_err[3*RW +: RW]   = 6'h2A;
            rdy = tbl[i].r;
            #1;
            chk($sformatf("t1[%0d] ready", i), ready_vec, tbl[i].x_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("t1[%0d] grant", i), grant, tbl[i].x_gnt);
            chk($sformatf("t1[%0d] busy", i), busy, tbl[i].x_busy);
            chk($sformatf("t1[%0d] valid", i), o_valid, tbl[i].x_ov);
            if (tbl[i].x_ov) begin
                chk($sformatf("t1[%0d] sop/eop", i), {o_sop, o_eop}, {tbl[i].x_sop, tbl[i].x_eop});
                chk($sformatf("t1[%0d] channel", i), o_ch, 3);
                chk($sformatf("t1[%0d] data", i), o_data, DW'(tbl[i].x_data));
                chk($sformatf("t1[%0d] empty", i), o_empty, tbl[i].x_emp);
                chk($sformatf("t1[%0d] error", i), o_err, 6'h2A);
            end
            @(negedge clk);
        end

        // All ports continuously request 2-beat packets: rotation and 1-cycle gaps.
        do_reset();
        for (int p = 0; p < NP; p++) begin m_len[p] = 2; m_pkts[p] = 2; end
        k = 0;
        while (mon.size() < 32 && k < 200) begin step(); k++; end
        chk("t2 beat count", mon.size(), 32);
        for (int i = 0; i < mon.size() / 2; i++) begin
            chk($sformatf("t2 pkt%0d ch", i), {mon[2*i].ch, mon[2*i+1].ch}, {CW'(i % NP), CW'(i % NP)});
            chk($sformatf("t2 pkt%0d framing", i),
                {mon[2*i].sop, mon[2*i].eop, mon[2*i+1].sop, mon[2*i+1].eop}, 4'b1001);
            chk($sformatf("t2 pkt%0d data0", i), mon[2*i].data, beat_data(i % NP, i / NP, 0));
            chk($sformatf("t2 pkt%0d data1", i), mon[2*i+1].data, beat_data(i % NP, i / NP, 1));
            chk($sformatf("t2 pkt%0d contiguous", i), mon[2*i+1].c - mon[2*i].c, 1);
            if (i > 0) chk($sformatf("t2 pkt%0d gap", i), mon[2*i].c - mon[2*i-1].c, 2);
        end

        // Port 5, 3-beat packet with the downstream stalled 4 cycles after the first beat.
        do_reset();
        m_len[5] = 3; m_pkts[5] = 1;
        k = 0;
        drive_model();
        while (!o_valid && k < 10) begin step(); k++; end
        chk("t3 first beat seen", o_valid, 1);
        for (int i = 0; i < 4; i++) begin
            rdy = 1'b0;
            drive_model();
            #1;
            chk($sformatf("t3 stall%0d valid", i), o_valid, 1);
            chk($sformatf("t3 stall%0d data", i), o_data, beat_data(5, 0, 0));
            chk($sformatf("t3 stall%0d sop", i), o_sop, 1);
            chk($sformatf("t3 stall%0d ready5", i), ready_vec[5], 0);
            finish_cycle();
        end
        rdy = 1'b1;
        repeat (10) step();
        chk("t3 beat count", mon.size(), 3);
        for (int i = 0; i < mon.size(); i++) begin
            chk($sformatf("t3 beat%0d data", i), mon[i].data, beat_data(5, 0, i));
            chk($sformatf("t3 beat%0d eop", i), mon[i].eop, (i == 2));
        end

        // Port 2 mid-packet when port 0 raises SOP: port 0 waits for port 2's EOP.
        do_reset();
        m_len[2] = 4; m_pkts[2] = 1;
        k = 0;
        drive_model();
        #1;
        while (grant != 8'h04 && k < 10) begin finish_cycle(); drive_model(); #1; k++; end
        chk("t4 port2 granted", grant, 8'h04);
        finish_cycle();
        step();
        m_len[0] = 2; m_pkts[0] = 1;
        g0cyc = -1;
        for (int i = 0; i < 20; i++) begin
            drive_model();
            #1;
            if (grant == 8'h01 && g0cyc < 0) g0cyc = cyc;
            finish_cycle();
        end
        chk("t4 grant0 timing", g0cyc, eop_cyc[2] + 1);
        chk("t4 beat count", mon.size(), 6);
        if (mon.size() == 6) begin
            chk("t4 order", {mon[3].ch, mon[3].eop, mon[4].ch, mon[4].sop}, {CW'(2), 1'b1, CW'(0), 1'b1});
            chk("t4 gap", mon[4].c - mon[3].c, 2);
        end

        // Port 0 disabled: only port 1 is served.
        do_reset();
        port_en = 8'hFE;
        m_len[0] = 2; m_pkts[0] = 1;
        m_len[1] = 2; m_pkts[1] = 1;
        rdy0_seen = 0;
        for (int i = 0; i < 15; i++) begin
            drive_model();
            #1;
            if (ready_vec[0]) rdy0_seen++;
            finish_cycle();
        end
        chk("t5 port0 ready cycles", rdy0_seen, 0);
        chk("t5 beat count", mon.size(), 2);
        if (mon.size() > 0) chk("t5 channel", mon[0].ch, 1);
        chk("t5 port0 pending", m_pkts[0], 1);
        chk("t5 port1 done", m_pkts[1], 0);
        port_en = '1;

        // Asynchronous reset mid-packet on port 4, then ports 0 and 4 race.
        do_reset();
        m_len[4] = 8; m_pkts[4] = 1;
        k = 0;
        drive_model();
        while (!o_valid && k < 10) begin step(); k++; end
        step();
        chk("t6 mid-packet busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6 async valid", o_valid, 0);
        chk("t6 async grant", grant, 0);
        chk("t6 async busy", busy, 0);
        chk("t6 async ready", ready_vec, 0);
        model_clear();
        drive_model();
        @(negedge clk);
        rst = 1'b0;
        m_len[0] = 1; m_pkts[0] = 1;
        m_len[4] = 1; m_pkts[4] = 1;
        step();
        chk("t6 first grant", grant, 8'h01);
        repeat (10) step();
        chk("t6 beat count", mon.size(), 2);
        if (mon.size() == 2) begin
            chk("t6 first pkt", {mon[0].ch, mon[0].sop, mon[0].eop}, {CW'(0), 2'b11});
            chk("t6 second pkt", {mon[1].ch, mon[1].sop, mon[1].eop}, {CW'(4), 2'b11});
            chk("t6 gap", mon[1].c - mon[0].c, 2);
        end
        chk("t6 released", {grant, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
